// File: rtl/display_pkg.sv
// Shared types and 7-segment constants for the result display path.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } disp_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  function automatic logic [6:0] seg7_encode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = SEG_ZERO;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/result_display_ctrl_if.sv
// Valid/ready product handoff from the multiplier core to the display controller.
interface result_display_ctrl_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             result_valid;
  logic [WIDTH-1:0] result;
  logic             result_ready;

  modport master (output result_valid, output result, input result_ready);
  modport slave  (input result_valid, input result, output result_ready);

endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed digit scanner: refresh counter, digit index, leading-zero blanking.
module seg7_scan
  import display_pkg::*;
#(
  parameter int unsigned NDIG        = 5,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4*NDIG-1:0] bcd,
  input  logic              ovf,
  output logic [NDIG-1:0]   an_o,
  output logic [6:0]        seg_o
);

  localparam int unsigned RefW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [RefW-1:0] ref_q;
  logic [IdxW-1:0] idx_q;
  logic [3:0]      digit;
  logic            blank;

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= '0;
      idx_q <= '0;
    end else if (ref_q == RefW'(REFRESH_DIV - 1)) begin
      ref_q <= '0;
      idx_q <= (idx_q == IdxW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      ref_q <= ref_q + 1'b1;
    end
  end

  // A digit is blanked only if it and every more significant digit are zero.
  always_comb begin
    digit = 4'd0;
    blank = (idx_q != '0);
    for (int i = 0; i < int'(NDIG); i++) begin
      if (IdxW'(i) == idx_q) digit = bcd[4*i +: 4];
      if (i >= int'(idx_q) && bcd[4*i +: 4] != 4'd0) blank = 1'b0;
    end
  end

  always_comb begin
    an_o = ~(NDIG'(1) << idx_q);
    if (ovf) begin
      seg_o = SEG_E;
    end else if (blank) begin
      seg_o = SEG_BLANK;
    end else begin
      seg_o = seg7_encode(digit);
    end
  end

endmodule

// File: rtl/result_display_ctrl.sv
// Accepts a signed product, converts |product| to BCD by serial double-dabble,
// and holds it in display registers driving the scanned 7-segment display.
module result_display_ctrl
  import display_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned NDIG        = 5,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  result_display_ctrl_if.slave  res,
  output logic                  new_result,
  output logic                  neg,
  output logic                  ovf,
  output logic [NDIG-1:0]       an_o,
  output logic [6:0]            seg_o
);

  localparam int unsigned BcdW     = 4 * NDIG;
  localparam int unsigned CntW     = $clog2(WIDTH + 1);
  localparam logic [63:0] OvfLimit = 64'(10 ** NDIG);

  disp_state_t     state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d, mag_in;
  logic [BcdW-1:0]  bcd_q, bcd_d, bcd_adj, disp_bcd_q;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sign_q, sign_d, ovfn_q, ovfn_d;
  logic             take, load_disp;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Conversion holds one extra CONVERT cycle at cnt==0 to load the display registers.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (res.result_valid) state_d = CONVERT;
      CONVERT: if (cnt_q == '0)      state_d = UPDATE;
      UPDATE:                        state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_comb begin
    res.result_ready = (state_q == IDLE);
    take             = (state_q == IDLE) && res.result_valid;
    load_disp        = (state_q == CONVERT) && (cnt_q == '0);
    new_result       = (state_q == UPDATE);
  end

  always_comb begin
    mag_in = res.result[WIDTH-1] ? (~res.result + 1'b1) : res.result;
    for (int i = 0; i < int'(NDIG); i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                      : bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    mag_d  = mag_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    sign_d = sign_q;
    ovfn_d = ovfn_q;
    if (take) begin
      mag_d  = mag_in;
      bcd_d  = '0;
      cnt_d  = CntW'(WIDTH);
      sign_d = res.result[WIDTH-1];
      ovfn_d = (64'(mag_in) >= OvfLimit);
    end else if (state_q == CONVERT && cnt_q != '0) begin
      bcd_d = {bcd_adj[BcdW-2:0], mag_q[WIDTH-1]};
      mag_d = {mag_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      ovfn_q     <= 1'b0;
      disp_bcd_q <= '0;
      neg        <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      mag_q  <= mag_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      sign_q <= sign_d;
      ovfn_q <= ovfn_d;
      if (load_disp) begin
        disp_bcd_q <= bcd_q;
        neg        <= sign_q;
        ovf        <= ovfn_q;
      end
    end
  end

  seg7_scan #(
    .NDIG        (NDIG),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .clk   (clk),
    .rst   (rst),
    .bcd   (disp_bcd_q),
    .ovf   (ovf),
    .an_o  (an_o),
    .seg_o (seg_o)
  );

endmodule
